// File: rtl/avmm_master_stub.sv
// avmm_master_stub: far-side Avalon-MM master endpoint. It pops request
// packets from the request FIFO, executes them against an internal word
// memory, and pushes response packets into the response FIFO.
//
// Handshake: the request FIFO is show-ahead. req_rdreq_o is asserted
// combinationally whenever the FSM can accept a word and !req_rdempty_i.
// The word on req_q_i is consumed on the clock edge where req_rdreq_o is high.
// The response side has no backpressure. resp_data_o is pushed on every cycle
// where resp_valid_o is high.
module avmm_master_stub #(
  parameter int MAX_BURST  = 64,
  parameter int BURSTCNT_W = 7,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  req_rdreq_o,
  input  logic [31:0]           req_q_i,
  input  logic                  req_rdempty_i,
  input  logic [BURSTCNT_W-1:0] req_rdusedw_i,
  output logic [31:0]           resp_data_o,
  output logic                  resp_valid_o,
  output logic [2:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RHDR  = 3'd4,
    RDATA = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  op_q, op_d;            // 1 = read
  logic [3:0]            be_q, be_d;
  logic [BURSTCNT_W-1:0] burst_q, burst_d;      // effective burstcount, never 0
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;          // beat index within the burst
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  resp_valid_q, resp_valid_d;

  logic [31:0]           mem [2**MEM_AW];
  logic                  pop;
  logic [MEM_AW-1:0]     beat_addr;
  logic [31:0]           hdr_w;
  logic                  unused_bits;

  // Fill level and the ignored header/address bits do not steer anything.
  assign unused_bits = ^{req_rdusedw_i, req_q_i};

  // The address wraps naturally because it is MEM_AW bits wide.
  assign beat_addr   = addr_q + MEM_AW'(cnt_q);
  assign req_rdreq_o = pop;
  assign resp_data_o  = resp_data_q;
  assign resp_valid_o = resp_valid_q;
  assign dbg_state_o  = state_q;

  // Response header: opcode echo plus effective burstcount, all else zero.
  always_comb begin
    hdr_w = '0;
    hdr_w[31] = op_q;
    hdr_w[BURSTCNT_W-1:0] = burst_q;
  end

  // Next-state, pop request and registered-response inputs.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    be_d         = be_q;
    burst_d      = burst_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        pop = !req_rdempty_i && !rst_i;
        if (pop) begin
          op_d    = req_q_i[31];
          be_d    = req_q_i[27:24];
          burst_d = (req_q_i[BURSTCNT_W-1:0] == '0) ? BURSTCNT_W'(1)
                                                     : req_q_i[BURSTCNT_W-1:0];
          state_d = ADDR;
        end
      end
      ADDR: begin
        pop = !req_rdempty_i && !rst_i;
        if (pop) begin
          addr_d = req_q_i[MEM_AW-1:0];
          cnt_d  = '0;
          if (op_q) begin
            state_d      = RHDR;
            resp_valid_d = 1'b1;
            resp_data_d  = hdr_w;
          end else begin
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        pop = !req_rdempty_i && !rst_i;
        if (pop) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(burst_q - 1'b1)) begin
            state_d      = WRESP;
            resp_valid_d = 1'b1;
            resp_data_d  = hdr_w;
          end
        end
      end
      WRESP: begin
        state_d = IDLE;
      end
      RHDR: begin
        resp_valid_d = 1'b1;
        resp_data_d  = mem[beat_addr];
        cnt_d        = cnt_q + 1'b1;
        state_d      = RDATA;
      end
      RDATA: begin
        if (cnt_q == CNT_W'(burst_q)) begin
          state_d = IDLE;
        end else begin
          resp_valid_d = 1'b1;
          resp_data_d  = mem[beat_addr];
          cnt_d        = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      be_q         <= '0;
      burst_q      <= BURSTCNT_W'(1);
      addr_q       <= '0;
      cnt_q        <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      be_q         <= be_d;
      burst_q      <= burst_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Byte-lane masked memory write. The memory has no reset, so partially
  // written bursts survive a reset.
  always_ff @(posedge clk_i) begin
    if (state_q == WDATA && pop) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) mem[beat_addr][8*k +: 8] <= req_q_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avmm_master_stub.sv
// Directed bench for avmm_master_stub. A queue models the show-ahead request
// FIFO, a word array models the memory, and exp_q holds the expected
// response words in order.
module tb_avmm_master_stub;

  localparam int W = 32;

  logic         clk;
  logic         rst_i;
  logic         req_rdreq_o;
  logic [31:0]  req_q_i;
  logic         req_rdempty_i;
  logic [6:0]   req_rdusedw_i;
  logic [31:0]  resp_data_o;
  logic         resp_valid_o;
  logic [2:0]   dbg_state_o;

  logic [W-1:0] exp_q[$];
  logic [31:0]  fifo[$];
  logic [31:0]  model_mem [1024];
  logic         pop_pend;
  int           checks = 0;
  int           errors = 0;

  avmm_master_stub #(.MAX_BURST(64), .BURSTCNT_W(7), .MEM_AW(10)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_rdreq_o   (req_rdreq_o),
    .req_q_i       (req_q_i),
    .req_rdempty_i (req_rdempty_i),
    .req_rdusedw_i (req_rdusedw_i),
    .resp_data_o   (resp_data_o),
    .resp_valid_o  (resp_valid_o),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the FIFO head, empty flag and fill level from the queue.
  task refresh();
    req_q_i       = (fifo.size() > 0) ? fifo[0] : 32'h0;
    req_rdempty_i = (fifo.size() == 0);
    req_rdusedw_i = 7'(fifo.size());
  endtask

  // FIFO model: remember a pop at the edge, retire the head at the next negedge.
  always @(posedge clk) pop_pend <= req_rdreq_o;
  always @(negedge clk) begin
    if (pop_pend) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      refresh();
    end
  end

  // Never a pop while the FIFO is empty.
  always @(posedge clk) begin
    #1;
    check("rdreq_while_empty", {31'b0, req_rdreq_o & req_rdempty_i}, 32'h0);
  end

  // Scoreboard: every valid response word must match the queue head.
  always @(negedge clk) begin
    if (!rst_i && resp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL resp_extra: observed=%h expected=none", resp_data_o);
      end else begin
        check("resp_word", resp_data_o, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic send_write(input int addr, input int n, input logic [3:0] be,
                            input logic [31:0] base, input logic [31:0] step);
    logic [31:0] d, old;
    int a;
    @(negedge clk);
    fifo.push_back({4'b0, be, 24'h0} | 32'(n));
    fifo.push_back(32'(addr));
    for (int i = 0; i < n; i++) begin
      d = base + 32'(i) * step;
      fifo.push_back(d);
      a = (addr + i) & 1023;
      old = model_mem[a];
      for (int k = 0; k < 4; k++) if (be[k]) old[8*k +: 8] = d[8*k +: 8];
      model_mem[a] = old;
    end
    exp_q.push_back(32'(n));
    refresh();
  endtask

  task automatic send_read(input int addr, input int n_field);
    int eff;
    eff = (n_field == 0) ? 1 : n_field;
    @(negedge clk);
    fifo.push_back(32'h8F00_0000 | 32'(n_field));
    fifo.push_back(32'(addr));
    exp_q.push_back(32'h8000_0000 | 32'(eff));
    for (int i = 0; i < eff; i++) exp_q.push_back(model_mem[(addr + i) & 1023]);
    refresh();
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || resp_valid_o) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_left", 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a, n;
    logic [31:0] b;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    rst_i = 1'b1;
    refresh();
    repeat (3) @(negedge clk);
    check("rst_rdreq", {31'b0, req_rdreq_o}, 32'h0);
    check("rst_valid", {31'b0, resp_valid_o}, 32'h0);
    check("rst_data", resp_data_o, 32'h0);
    check("rst_state", {29'b0, dbg_state_o}, 32'h0);
    rst_i = 1'b0;

    // Single write: ack the cycle after the data pop, then drop.
    send_write(32'h10, 1, 4'hF, 32'hDEADBEEF, 32'h0);
    repeat (3) @(negedge clk);
    check("wr_ack_valid", {31'b0, resp_valid_o}, 32'h1);
    check("wr_ack_word", resp_data_o, 32'h0000_0001);
    @(negedge clk);
    check("wr_ack_drop", {31'b0, resp_valid_o}, 32'h0);
    wait_drain();

    // Single read: header one cycle after address pop, data next, then drop.
    send_read(32'h10, 1);
    repeat (2) @(negedge clk);
    check("rd_hdr_valid", {31'b0, resp_valid_o}, 32'h1);
    check("rd_hdr_word", resp_data_o, 32'h8000_0001);
    @(negedge clk);
    check("rd_data_word", resp_data_o, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_drop", {31'b0, resp_valid_o}, 32'h0);
    wait_drain();

    // Byte-enable write: 0x11223344 merged with 0xAABBCCDD on lanes 0 and 2.
    send_write(5, 1, 4'hF, 32'h11223344, 32'h0);
    send_write(5, 1, 4'h5, 32'hAABBCCDD, 32'h0);
    check("be_model", model_mem[5], 32'h11BB33DD);
    send_read(5, 1);
    wait_drain();

    // Wrapping burst of 8 at the top of memory, then the wrapped low words.
    send_write(1020, 8, 4'hF, 32'h1, 32'h1);
    send_read(1020, 8);
    send_read(0, 4);
    check("wrap_model", model_mem[3], 32'h8);
    wait_drain();

    // Starved FIFO: header now, address ten cycles later.
    exp_q.push_back(32'h8000_0001);
    exp_q.push_back(model_mem[32'h10]);
    @(negedge clk);
    fifo.push_back(32'h8F00_0001);
    refresh();
    #1 check("starve_rdreq_hdr", {31'b0, req_rdreq_o}, 32'h1);
    repeat (10) @(negedge clk);
    check("starve_stall_rdreq", {31'b0, req_rdreq_o}, 32'h0);
    check("starve_stall_state", {29'b0, dbg_state_o}, 32'h1);
    fifo.push_back(32'h10);
    refresh();
    #1 check("starve_rdreq_addr", {31'b0, req_rdreq_o}, 32'h1);
    @(negedge clk);
    check("starve_hdr_latency", {31'b0, resp_valid_o}, 32'h1);
    wait_drain();

    // Burstcount 0 read behaves as a single-word read.
    send_read(32'h10, 0);
    // Largest burst.
    send_write(200, 64, 4'hF, $urandom, 32'h3);
    send_read(200, 64);
    wait_drain();

    // Randomised write / masked overwrite / read-back.
    for (int r = 0; r < 4; r++) begin
      a = $urandom_range(0, 1023);
      n = $urandom_range(1, 8);
      b = $urandom;
      send_write(a, n, 4'hF, b, $urandom);
      send_write(a, n, 4'($urandom_range(0, 15)), ~b, $urandom);
      send_read(a, n);
    end
    wait_drain();

    // Reset in the middle of a write burst: two of four beats delivered.
    @(negedge clk);
    fifo.push_back(32'h0F00_0004);
    fifo.push_back(32'd100);
    fifo.push_back(32'hA5A5_0001);
    fifo.push_back(32'hA5A5_0002);
    model_mem[100] = 32'hA5A5_0001;
    model_mem[101] = 32'hA5A5_0002;
    refresh();
    repeat (8) @(negedge clk);
    check("midrst_stall_state", {29'b0, dbg_state_o}, 32'h2);
    rst_i = 1'b1;
    #1;
    check("midrst_valid", {31'b0, resp_valid_o}, 32'h0);
    check("midrst_data", resp_data_o, 32'h0);
    check("midrst_state", {29'b0, dbg_state_o}, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    send_read(100, 2);
    wait_drain();

    check("final_queue", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
